// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional 2-entry skid buffer
module pipe_stage_reg #(
   parameter int Width = 32,
   parameter bit Skid  = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o,
   output logic [1:0]       occupancy_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [Width-1:0] main_q;
   logic [Width-1:0] skid_q;
   logic             in_xfer, out_xfer;
   logic             main_load, main_from_skid, skid_load;

   assign valid_o     = (state_q != EMPTY);
   assign occupancy_o = state_q;
   assign data_o      = main_q;
   assign in_xfer     = valid_i & ready_o;
   assign out_xfer    = valid_o & ready_i;

   // With the skid buffer, ready depends only on the state register.
   generate
      if (Skid) begin : g_ready_reg
         assign ready_o = (state_q != FULL);
      end else begin : g_ready_comb
         assign ready_o = !valid_o | ready_i;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d   = HALF;
               main_load = 1'b1;
            end
         end
         HALF: begin
            if (in_xfer && out_xfer) begin
               main_load = 1'b1;
            end else if (in_xfer) begin
               // Only reachable with the skid buffer; without it ready implies out.
               if (Skid) begin
                  state_d   = FULL;
                  skid_load = 1'b1;
               end
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_d        = HALF;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) begin
         state_d   = EMPTY;
         main_load = 1'b0;
         skid_load = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_q <= '0;
      end else if (main_load) begin
         main_q <= main_from_skid ? skid_q : data_i;
      end
   end

   generate
      if (Skid) begin : g_skid
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               skid_q <= '0;
            end else if (skid_load) begin
               skid_q <= data_i;
            end
         end
      end else begin : g_no_skid
         assign skid_q = '0;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg in both modes
module tb_pipe_stage_reg;

   logic        clk;
   // Skid=1, Width=32 instance
   logic        rst, flush, vin, rdy;
   logic [31:0] din;
   logic        rdy_o, vout;
   logic [31:0] dout;
   logic [1:0]  occ;
   // Skid=0, Width=97 instance
   logic        f_rst, f_flush, f_vin, f_rdy;
   logic [96:0] f_din;
   logic        f_rdy_o, f_vout;
   logic [96:0] f_dout;
   logic [1:0]  f_occ;

   int total = 0;
   int bad   = 0;

   logic [96:0] d1, d2, d3;

   pipe_stage_reg #(.Width(32), .Skid(1'b1)) u_skid (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(rdy_o),
      .data_i(din), .valid_o(vout), .ready_i(rdy), .data_o(dout), .occupancy_o(occ)
   );

   pipe_stage_reg #(.Width(97), .Skid(1'b0)) u_flat (
      .clk_i(clk), .rst_i(f_rst), .flush_i(f_flush), .valid_i(f_vin), .ready_o(f_rdy_o),
      .data_i(f_din), .valid_o(f_vout), .ready_i(f_rdy), .data_o(f_dout), .occupancy_o(f_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; vin = 1'b1; din = 32'hFF; rdy = 1'b1;
      f_rst = 1'b1; f_flush = 1'b0; f_vin = 1'b1; f_din = '1; f_rdy = 1'b1;
      d1 = {1'b1, 96'h0123_4567_89AB_CDEF_0000_00A1};
      d2 = {1'b0, 96'hFEDC_BA98_7654_3210_FFFF_FFB2};
      d3 = {1'b1, 96'h5555_AAAA_5555_AAAA_5555_AAC3};

      // reset for two cycles; offered transfers are ignored
      step(); step();
      chk("rst_valid", 128'(vout), 128'(1'b0));
      chk("rst_occ", 128'(occ), 128'(2'd0));
      chk("rst_ready", 128'(rdy_o), 128'(1'b1));
      chk("rst_data", 128'(dout), 128'(32'h0));
      chk("f_rst_valid", 128'(f_vout), 128'(1'b0));
      chk("f_rst_data", 128'(f_dout), 128'(97'h0));
      rst = 1'b0; f_rst = 1'b0; f_vin = 1'b0;

      // stream 1,2,3 at full rate
      din = 32'h1; step();
      chk("s1_data", 128'(dout), 128'(32'h1));
      chk("s1_occ", 128'(occ), 128'(2'd1));
      din = 32'h2; step();
      chk("s2_data", 128'(dout), 128'(32'h2));
      chk("s2_valid", 128'(vout), 128'(1'b1));
      din = 32'h3; step();
      chk("s3_data", 128'(dout), 128'(32'h3));
      chk("s3_occ", 128'(occ), 128'(2'd1));
      vin = 1'b0; step();
      chk("s_drain_valid", 128'(vout), 128'(1'b0));

      // skid fill: B offered in the cycle ready_i drops
      vin = 1'b1; din = 32'hA; step();
      chk("k_a_data", 128'(dout), 128'(32'hA));
      din = 32'hB; rdy = 1'b0; step();
      chk("k_full_occ", 128'(occ), 128'(2'd2));
      chk("k_full_ready", 128'(rdy_o), 128'(1'b0));
      chk("k_full_data", 128'(dout), 128'(32'hA));
      din = 32'hC; step();
      chk("k_hold_data", 128'(dout), 128'(32'hA));
      chk("k_hold_occ", 128'(occ), 128'(2'd2));
      rdy = 1'b1; step();
      chk("k_b_data", 128'(dout), 128'(32'hB));
      chk("k_b_occ", 128'(occ), 128'(2'd1));
      chk("k_b_ready", 128'(rdy_o), 128'(1'b1));
      step();
      chk("k_c_data", 128'(dout), 128'(32'hC));
      chk("k_c_valid", 128'(vout), 128'(1'b1));
      vin = 1'b0; step();
      chk("k_drain_valid", 128'(vout), 128'(1'b0));

      // flush while full, with 0xD offered in the flush cycle
      vin = 1'b1; din = 32'h11; rdy = 1'b0; step();
      din = 32'h22; step();
      chk("f_full_occ", 128'(occ), 128'(2'd2));
      flush = 1'b1; din = 32'hD; step();
      chk("fl_valid", 128'(vout), 128'(1'b0));
      chk("fl_occ", 128'(occ), 128'(2'd0));
      chk("fl_ready", 128'(rdy_o), 128'(1'b1));
      flush = 1'b0; vin = 1'b0; rdy = 1'b1; step();
      chk("fl_after_valid", 128'(vout), 128'(1'b0));

      // stall stability
      vin = 1'b1; din = 32'h55; rdy = 1'b0; step();
      vin = 1'b0; din = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("st_data", 128'(dout), 128'(32'h55));
         chk("st_valid", 128'(vout), 128'(1'b1));
         step();
      end
      rdy = 1'b1; step();
      chk("st_drain_valid", 128'(vout), 128'(1'b0));

      // reset while full
      vin = 1'b1; din = 32'h66; rdy = 1'b0; step();
      din = 32'h77; step();
      chk("r_full_occ", 128'(occ), 128'(2'd2));
      rst = 1'b1; step();
      chk("r_valid", 128'(vout), 128'(1'b0));
      chk("r_data", 128'(dout), 128'(32'h0));
      chk("r_occ", 128'(occ), 128'(2'd0));
      chk("r_ready", 128'(rdy_o), 128'(1'b1));
      rst = 1'b0; vin = 1'b0; rdy = 1'b1;

      // Skid=0, Width=97: full rate, combinational ready, bit 96 intact
      f_vin = 1'b1; f_din = d1; f_rdy = 1'b1; step();
      chk("w_d1_data", 128'(f_dout), 128'(d1));
      chk("w_d1_occ", 128'(f_occ), 128'(2'd1));
      f_din = d2; step();
      chk("w_d2_data", 128'(f_dout), 128'(d2));
      f_vin = 1'b0; f_rdy = 1'b0; #1;
      chk("w_ready_lo", 128'(f_rdy_o), 128'(1'b0));
      f_rdy = 1'b1; #1;
      chk("w_ready_hi", 128'(f_rdy_o), 128'(1'b1));
      f_rdy = 1'b0; step();
      chk("w_stall_data", 128'(f_dout), 128'(d2));
      chk("w_stall_valid", 128'(f_vout), 128'(1'b1));
      f_vin = 1'b1; f_din = d3; f_rdy = 1'b1; step();
      chk("w_d3_data", 128'(f_dout), 128'(d3));
      chk("w_d3_valid", 128'(f_vout), 128'(1'b1));
      f_vin = 1'b0; step();
      chk("w_drain_valid", 128'(f_vout), 128'(1'b0));
      f_rdy = 1'b0; #1;
      chk("w_empty_ready", 128'(f_rdy_o), 128'(1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
